// File: rtl/triangle_setup.sv
// Triangle setup: culls degenerate/off-screen triangles, normalises winding, builds a clamped
// pixel bbox and computes 1/area. Define TRIANGLE_SETUP_BACKFACE_CULL_EN to also cull back faces.
module triangle_setup #(
  parameter int SCREEN_WIDTH  = 320,
  parameter int SCREEN_HEIGHT = 240
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   valid_in,
  output logic                   ready_out,
  input  logic [2:0][1:0][16:0]  vertices_in,
  input  logic                   negative_in,
  input  logic [33:0]            area_in,
  output logic                   valid_out,
  input  logic                   ready_in,
  output logic [2:0][1:0][16:0]  vertices_out,
  output logic [1:0][8:0]        bbox_min_out,
  output logic [1:0][8:0]        bbox_max_out,
  output logic [31:0]            inv_area_out
);

  typedef enum logic [1:0] {IDLE, CHECK, DIVIDE, DONE} state_t;

  localparam logic [9:0]  X_LIMIT = 10'(SCREEN_WIDTH);
  localparam logic [9:0]  Y_LIMIT = 10'(SCREEN_HEIGHT);
  localparam logic [8:0]  X_CLAMP = 9'(SCREEN_WIDTH - 1);
  localparam logic [8:0]  Y_CLAMP = 9'(SCREEN_HEIGHT - 1);
  localparam logic [33:0] AREA_ONE = 34'h1_0000;

  state_t                 state;
  logic [2:0][1:0][16:0]  vert_q;
  logic                   neg_q;
  logic [33:0]            area_q;
  logic [34:0]            rem_q;
  logic [31:0]            quo_q;
  logic [4:0]             count_q;

  logic [8:0]             min_x, max_x, min_y, max_y;
  logic [8:0]             max_x_clamped, max_y_clamped;
  logic [2:0][1:0][16:0]  vert_wound;
  logic                   backface_cull;
  logic                   cull;
  logic [34:0]            rem_shift, rem_next;
  logic                   rem_fits;
  logic [31:0]            quo_next;

  always_comb begin
    min_x = vert_q[0][0][16:8];
    max_x = vert_q[0][0][16:8];
    min_y = vert_q[0][1][16:8];
    max_y = vert_q[0][1][16:8];
    for (int i = 1; i < 3; i++) begin
      if (vert_q[i][0][16:8] < min_x) min_x = vert_q[i][0][16:8];
      if (vert_q[i][0][16:8] > max_x) max_x = vert_q[i][0][16:8];
      if (vert_q[i][1][16:8] < min_y) min_y = vert_q[i][1][16:8];
      if (vert_q[i][1][16:8] > max_y) max_y = vert_q[i][1][16:8];
    end
  end

  assign max_x_clamped = (max_x > X_CLAMP) ? X_CLAMP : max_x;
  assign max_y_clamped = (max_y > Y_CLAMP) ? Y_CLAMP : max_y;

  // Clockwise triangles become counter-clockwise by exchanging vertices 1 and 2.
  always_comb begin
    vert_wound = vert_q;
    if (neg_q) begin
      vert_wound[1] = vert_q[2];
      vert_wound[2] = vert_q[1];
    end
  end

`ifdef TRIANGLE_SETUP_BACKFACE_CULL_EN
  assign backface_cull = neg_q;
`else
  assign backface_cull = 1'b0;
`endif

  assign cull = (area_q == '0)
             || ({1'b0, min_x} >= X_LIMIT)
             || ({1'b0, min_y} >= Y_LIMIT)
             || backface_cull;

  // Restoring division of 2^48 by area: remainder starts at 2^16 (always < area here)
  // and every remaining dividend bit is zero, so each step is a plain shift-and-compare.
  assign rem_shift = {rem_q[33:0], 1'b0};
  assign rem_fits  = rem_q[34] || (rem_shift >= {1'b0, area_q});
  assign rem_next  = rem_fits ? (rem_shift - {1'b0, area_q}) : rem_shift;
  assign quo_next  = {quo_q[30:0], rem_fits};

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state        <= IDLE;
      ready_out    <= 1'b1;
      valid_out    <= 1'b0;
      vert_q       <= '0;
      neg_q        <= 1'b0;
      area_q       <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      count_q      <= '0;
      vertices_out <= '0;
      bbox_min_out <= '0;
      bbox_max_out <= '0;
      inv_area_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_in && ready_out) begin
            vert_q    <= vertices_in;
            neg_q     <= negative_in;
            area_q    <= area_in;
            ready_out <= 1'b0;
            state     <= CHECK;
          end
        end
        CHECK: begin
          if (cull) begin
            ready_out <= 1'b1;
            state     <= IDLE;
          end else begin
            vertices_out    <= vert_wound;
            bbox_min_out[0] <= min_x;
            bbox_min_out[1] <= min_y;
            bbox_max_out[0] <= max_x_clamped;
            bbox_max_out[1] <= max_y_clamped;
            // Areas up to 1.0 pixel would overflow 0.32 format, so saturate without dividing.
            if (area_q <= AREA_ONE) begin
              inv_area_out <= '1;
              valid_out    <= 1'b1;
              state        <= DONE;
            end else begin
              rem_q   <= 35'h1_0000;
              quo_q   <= '0;
              count_q <= '0;
              state   <= DIVIDE;
            end
          end
        end
        DIVIDE: begin
          rem_q   <= rem_next;
          quo_q   <= quo_next;
          count_q <= count_q + 5'd1;
          if (count_q == 5'd31) begin
            inv_area_out <= quo_next;
            valid_out    <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          if (ready_in) begin
            valid_out <= 1'b0;
            ready_out <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_triangle_setup.sv
// Self-checking bench for triangle_setup: directed cases plus random triangles against
// an arithmetic reference model of cull, winding, bbox and reciprocal rules.
module tb_triangle_setup;

  typedef logic [2:0][1:0][16:0] vert_t;

  logic         clk_in;
  logic         rst_in;
  logic         valid_in;
  logic         ready_out;
  vert_t        vertices_in;
  logic         negative_in;
  logic [33:0]  area_in;
  logic         valid_out;
  logic         ready_in;
  vert_t        vertices_out;
  logic [1:0][8:0] bbox_min_out;
  logic [1:0][8:0] bbox_max_out;
  logic [31:0]  inv_area_out;

  int checks = 0;
  int errors = 0;

  triangle_setup #(.SCREEN_WIDTH(320), .SCREEN_HEIGHT(240)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .valid_in     (valid_in),
    .ready_out    (ready_out),
    .vertices_in  (vertices_in),
    .negative_in  (negative_in),
    .area_in      (area_in),
    .valid_out    (valid_out),
    .ready_in     (ready_in),
    .vertices_out (vertices_out),
    .bbox_min_out (bbox_min_out),
    .bbox_max_out (bbox_max_out),
    .inv_area_out (inv_area_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic vert_t mkTri(input int x0, input int y0, input int x1, input int y1,
                                  input int x2, input int y2);
    vert_t v;
    v[0][0] = 17'(x0 * 256); v[0][1] = 17'(y0 * 256);
    v[1][0] = 17'(x1 * 256); v[1][1] = 17'(y1 * 256);
    v[2][0] = 17'(x2 * 256); v[2][1] = 17'(y2 * 256);
    return v;
  endfunction

  // Reference model: pixel integer parts, min/max, clamp, culls and long-hand reciprocal.
  task automatic modelTri(input vert_t v, input logic neg, input logic [33:0] area,
                          output bit culled, output int latency, output vert_t exp_v,
                          output logic [1:0][8:0] exp_min, output logic [1:0][8:0] exp_max,
                          output logic [31:0] exp_inv);
    int lo_x = 1000, hi_x = -1, lo_y = 1000, hi_y = -1;
    for (int i = 0; i < 3; i++) begin
      int px = int'(v[i][0]) / 256;
      int py = int'(v[i][1]) / 256;
      if (px < lo_x) lo_x = px;
      if (px > hi_x) hi_x = px;
      if (py < lo_y) lo_y = py;
      if (py > hi_y) hi_y = py;
    end
    culled = (area == 0) || (lo_x >= 320) || (lo_y >= 240);
`ifdef TRIANGLE_SETUP_BACKFACE_CULL_EN
    culled = culled || neg;
`endif
    if (hi_x > 319) hi_x = 319;
    if (hi_y > 239) hi_y = 239;
    exp_min[0] = 9'(lo_x); exp_min[1] = 9'(lo_y);
    exp_max[0] = 9'(hi_x); exp_max[1] = 9'(hi_y);
    exp_v = neg ? {v[1], v[2], v[0]} : v;
    if (area <= 34'h1_0000) begin
      exp_inv = 32'hFFFF_FFFF;
      latency = 2;
    end else begin
      exp_inv = 32'((64'd1 << 48) / {30'd0, area});
      latency = 34;
    end
  endtask

  task automatic applyStimulus(input vert_t v, input logic neg, input logic [33:0] area);
    int waited = 0;
    @(negedge clk_in);
    while (ready_out !== 1'b1 && waited < 100) begin
      @(negedge clk_in);
      waited++;
    end
    checkOutput("ready_before_accept", ready_out, 1);
    vertices_in = v;
    negative_in = neg;
    area_in     = area;
    valid_in    = 1'b1;
    @(posedge clk_in);
    #1;
    valid_in = 1'b0;
  endtask

  // Called right after the acceptance edge (edge 1); waits for the result and completes it.
  task automatic verifyTriangle(input string tag, input vert_t v, input logic neg,
                                input logic [33:0] area, input int hold_cycles);
    bit culled;
    int latency;
    vert_t exp_v;
    logic [1:0][8:0] exp_min, exp_max;
    logic [31:0] exp_inv;
    int edge_n = 1;
    modelTri(v, neg, area, culled, latency, exp_v, exp_min, exp_max, exp_inv);
    checkOutput({tag, "_busy"}, ready_out, 0);
    if (culled) begin
      int ready_edge = 0;
      bit saw_valid = 0;
      while (edge_n < 40) begin
        @(posedge clk_in);
        #1;
        edge_n++;
        if (valid_out === 1'b1) saw_valid = 1;
        if (ready_out === 1'b1 && ready_edge == 0) ready_edge = edge_n;
      end
      checkOutput({tag, "_cull_ready_edge"}, 128'(ready_edge), 2);
      checkOutput({tag, "_cull_no_valid"}, 128'(saw_valid), 0);
    end else begin
      while (valid_out !== 1'b1 && edge_n < 60) begin
        @(posedge clk_in);
        #1;
        edge_n++;
      end
      checkOutput({tag, "_latency"}, 128'(edge_n), 128'(latency));
      checkOutput({tag, "_inv"}, inv_area_out, exp_inv);
      checkOutput({tag, "_bbox_min"}, bbox_min_out, exp_min);
      checkOutput({tag, "_bbox_max"}, bbox_max_out, exp_max);
      checkOutput({tag, "_verts"}, vertices_out, exp_v);
      for (int c = 0; c < hold_cycles; c++) begin
        @(negedge clk_in);
        valid_in    = 1'b1;
        vertices_in = mkTri(1, 1, 2, 2, 3, 1);
        negative_in = 1'b0;
        area_in     = 34'h3_0000;
        @(posedge clk_in);
        #1;
        checkOutput({tag, "_hold_valid"}, valid_out, 1);
        checkOutput({tag, "_hold_ready"}, ready_out, 0);
        checkOutput({tag, "_hold_inv"}, inv_area_out, exp_inv);
        checkOutput({tag, "_hold_bbox"}, {bbox_min_out, bbox_max_out}, {exp_min, exp_max});
        checkOutput({tag, "_hold_verts"}, vertices_out, exp_v);
      end
      @(negedge clk_in);
      valid_in = 1'b0;
      ready_in = 1'b1;
      @(posedge clk_in);
      #1;
      ready_in = 1'b0;
      checkOutput({tag, "_post_valid"}, valid_out, 0);
      checkOutput({tag, "_post_ready"}, ready_out, 1);
      if (hold_cycles > 0) begin
        bit stray = 0;
        for (int c = 0; c < 5; c++) begin
          @(posedge clk_in);
          #1;
          if (valid_out !== 1'b0 || ready_out !== 1'b1) stray = 1;
        end
        checkOutput({tag, "_ignored_input"}, 128'(stray), 0);
      end
    end
  endtask

  initial begin
    vert_t v;
    logic [31:0] r;
    logic [33:0] a;
    rst_in      = 1'b1;
    valid_in    = 1'b0;
    ready_in    = 1'b0;
    negative_in = 1'b0;
    area_in     = '0;
    vertices_in = '0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    checkOutput("reset_ready", ready_out, 1);
    checkOutput("reset_valid", valid_out, 0);
    checkOutput("reset_inv", inv_area_out, 0);
    checkOutput("reset_bbox", {bbox_min_out, bbox_max_out}, 0);
    checkOutput("reset_verts", vertices_out, 0);

    $display("[TB] normal triangle");
    v = mkTri(96, 4, 0, 83, 192, 83);
    applyStimulus(v, 1'b0, 34'h0_1DA0_0000);
    verifyTriangle("normal", v, 1'b0, 34'h0_1DA0_0000, 0);
    checkOutput("normal_inv_const", inv_area_out, 32'h0008_A42F);

    $display("[TB] divider and saturation boundaries");
    v = mkTri(10, 10, 20, 10, 10, 20);
    applyStimulus(v, 1'b0, 34'h2_0000);
    verifyTriangle("div_2", v, 1'b0, 34'h2_0000, 0);
    checkOutput("div_2_const", inv_area_out, 32'h8000_0000);
    applyStimulus(v, 1'b0, 34'h1_0000);
    verifyTriangle("sat_1", v, 1'b0, 34'h1_0000, 0);
    applyStimulus(v, 1'b0, 34'h8000);
    verifyTriangle("sat_half", v, 1'b0, 34'h8000, 0);
    applyStimulus(v, 1'b0, 34'h1_0001);
    verifyTriangle("div_just_above", v, 1'b0, 34'h1_0001, 0);
    applyStimulus(v, 1'b0, 34'h3_FFFF_FFFF);
    verifyTriangle("div_max", v, 1'b0, 34'h3_FFFF_FFFF, 0);

    $display("[TB] culling and clamping");
    applyStimulus(v, 1'b0, 34'h0);
    verifyTriangle("cull_zero", v, 1'b0, 34'h0, 0);
    v = mkTri(320, 10, 330, 20, 400, 30);
    applyStimulus(v, 1'b0, 34'h40_0000);
    verifyTriangle("cull_offx", v, 1'b0, 34'h40_0000, 0);
    v = mkTri(10, 240, 30, 250, 20, 300);
    applyStimulus(v, 1'b0, 34'h40_0000);
    verifyTriangle("cull_offy", v, 1'b0, 34'h40_0000, 0);
    v = mkTri(100, 10, 400, 20, 150, 300);
    applyStimulus(v, 1'b0, 34'h4000_0000);
    verifyTriangle("clamp", v, 1'b0, 34'h4000_0000, 0);
    checkOutput("clamp_const", bbox_max_out, {9'd239, 9'd319});

    $display("[TB] back-facing triangle");
    v = mkTri(96, 4, 0, 83, 192, 83);
    applyStimulus(v, 1'b1, 34'h0_1DA0_0000);
    verifyTriangle("backface", v, 1'b1, 34'h0_1DA0_0000, 0);

    $display("[TB] backpressure");
    v = mkTri(5, 6, 50, 60, 7, 90);
    applyStimulus(v, 1'b0, 34'h12_3456);
    verifyTriangle("backpressure", v, 1'b0, 34'h12_3456, 10);

    $display("[TB] reset during divide");
    v = mkTri(96, 4, 0, 83, 192, 83);
    applyStimulus(v, 1'b0, 34'h0_1DA0_0000);
    repeat (16) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    checkOutput("midreset_valid", valid_out, 0);
    checkOutput("midreset_ready", ready_out, 1);
    checkOutput("midreset_inv", inv_area_out, 0);
    v = mkTri(30, 40, 60, 40, 30, 100);
    applyStimulus(v, 1'b0, 34'h5_5555);
    verifyTriangle("after_reset", v, 1'b0, 34'h5_5555, 0);

    $display("[TB] random triangles");
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < 3; i++) begin
        v[i][0] = 17'($urandom_range(0, 17'h1FFFF));
        v[i][1] = 17'($urandom_range(0, 17'h13FFF));
      end
      r = $urandom();
      case ($urandom_range(0, 5))
        0:       a = 34'($urandom_range(0, 32'h1_0000));
        1:       a = '0;
        default: a = {r[1:0], 32'($urandom())};
      endcase
      applyStimulus(v, 1'($urandom_range(0, 1)), a);
      verifyTriangle("random", v, negative_in, a, int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/triangle_setup.md
Name: triangle_setup

Overview:
- Stage directly downstream of triangle_area.
- Takes screen-space vertices plus signed area, and culls degenerate, off-screen and (optionally) back-facing triangles.
- For surviving triangles, normalises winding, computes a clamped integer pixel bounding box, and computes 1/area with an iterative divider.
- Feeds the rasterizer through a valid/ready handshake.

Parameters:
- SCREEN_WIDTH, 320, horizontal pixel count; bbox x clamp upper bound is SCREEN_WIDTH-1.
- SCREEN_HEIGHT, 240, vertical pixel count; bbox y clamp upper bound is SCREEN_HEIGHT-1.

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  reset; synchronous, active-high.
- valid_in  input  1  upstream triangle valid.
- ready_out  output  1  block can accept a triangle.
- vertices_in  input  [2:0][1:0][16:0]  per vertex {y,x}; unsigned 9.8 fixed point; [i][0]=x, [i][1]=y.
- negative_in  input  1  signed-area sign from triangle_area.
- area_in  input  34  |area|, 18.16 fixed point.
- valid_out  output  1  setup result valid.
- ready_in  input  1  downstream ready.
- vertices_out  output  [2:0][1:0][16:0]  vertices, CCW-normalised.
- bbox_min_out  output  [1:0][8:0]  {y,x} inclusive minimum pixel.
- bbox_max_out  output  [1:0][8:0]  {y,x} inclusive maximum pixel.
- inv_area_out  output  32  1/area in 0.32 fixed point.

Behaviour:
- States: IDLE, CHECK, DIVIDE, DONE.
- Reset (any state, including mid-DIVIDE): state=IDLE, ready_out=1, valid_out=0. All data outputs, divider remainder/quotient/counter = 0. In-flight triangle is discarded.
- IDLE: ready_out=1. On valid_in&&ready_out, register vertices, sign and area, then go to CHECK. ready_out=0 in every other state.
- CHECK (1 cycle) evaluates, in priority order:
  1. area_in==0 -> cull.
  2. floor(min x) >= SCREEN_WIDTH or floor(min y) >= SCREEN_HEIGHT -> cull.
  3. Back-face rule (see Optional Feature).
  - Culled: return to IDLE; no output is produced.
- Winding: a surviving triangle with negative_in=1 swaps vertices 1 and 2 on vertices_out.
- Bbox:
  - min = floor of per-axis minimum coordinate (integer bits [16:8]).
  - max = floor of per-axis maximum coordinate.
  - max clamped to SCREEN_WIDTH-1 / SCREEN_HEIGHT-1; min never exceeds the clamp (guaranteed by the cull rule).
- Reciprocal: inv_area = floor(2^48 / area_in), i.e. floor(2^32 / A).
  - area_in <= 0x1_0000 (A <= 1.0): saturate to 0xFFFF_FFFF; go CHECK->DONE directly.
  - Otherwise: DIVIDE runs a restoring divider, 1 quotient bit per cycle, exactly 32 cycles, then DONE.
- DONE: valid_out=1. All outputs are held stable while ready_in=0. On ready_in, go to IDLE with valid_out=0 on the next cycle.
- Latency from acceptance edge:
  - Normal: valid_out high after edge 34.
  - Saturated: valid_out high after edge 2.
  - Culled: ready_out high again after edge 2.
- Throughput: at most one triangle in flight; no input accepted while in CHECK, DIVIDE or DONE.

Optional Feature:
- Macro: TRIANGLE_SETUP_BACKFACE_CULL_EN.
- Defined: negative_in=1 triangles are culled in CHECK, same timing as other culls.
- Undefined: negative_in=1 triangles survive, with vertices 1/2 swapped on output.

Test Plan:
- Normal triangle:
  - Stimulus: (96,4),(0,83),(192,83), negative_in=0, area_in=0x0_1DA0_0000.
  - Response: valid_out after 34 cycles; inv_area_out=566319 (0x0008_A42F); bbox_min {4,0}; bbox_max {83,192}; vertices unchanged.
- Divider and saturation boundaries:
  - area_in=0x2_0000 -> inv_area_out=0x8000_0000 after 34 cycles.
  - area_in=0x1_0000 -> 0xFFFF_FFFF after 2 cycles.
  - area_in=0x8000 -> 0xFFFF_FFFF after 2 cycles.
- Culling:
  - area_in=0 -> no valid_out; ready_out high 2 cycles after acceptance.
  - Vertices with all x >= 320.00 -> culled.
  - Bbox max x of 400 -> clamped to 319.
- Back-face, negative_in=1:
  - With the macro: culled.
  - Without the macro: output has v1/v2 swapped and the same bbox/inv_area.
- Backpressure: hold ready_in=0 for 10 cycles in DONE -> valid_out and all data stable; ready_out=0; new valid_in is ignored until handshake completes.
- Reset: assert rst_in at DIVIDE cycle 15 -> next cycle IDLE, valid_out=0, ready_out=1. A fresh triangle then completes correctly.
